sample_packer: RTL and testbench
================================

// Module: sample_packer
//
// PURPOSE
// Serial-to-parallel producer for the adder tree input interface. Collects a
// framed stream of single DATA_WIDTH samples into one NUM_INPUTS*DATA_WIDTH
// flat vector, then issues a one-cycle valid strobe. The outputs drive
// adder_tree_wrapper valid_in/data_in directly. Double-buffered: no stall,
// no backpressure; accepts one sample per clock indefinitely.
//
// PARAMETERS
// NUM_INPUTS  10  samples per frame = lanes in the output vector (>=1)
// DATA_WIDTH  16  bits per sample (signed two's complement, passed unchanged)
//
// PORTS
// clk           in   1                      single clock for the whole block
// rst           in   1                      synchronous reset, active-low (0 = reset)
// sample_valid  in   1                      sample_data/sample_first qualify this cycle
// sample_first  in   1                      sample is lane 0 of a new frame
// sample_data   in   DATA_WIDTH             sample value
// valid_out     out  1                      one-cycle strobe: data_out holds a new frame
// data_out      out  NUM_INPUTS*DATA_WIDTH  lane i at bits [i*DATA_WIDTH +: DATA_WIDTH]
// frame_err     out  1                      one-cycle pulse: framing violation
// in_sync       out  1                      1 while state is COLLECT
//
// BEHAVIOUR
// - Reset (rst==0 at a clk edge): state HUNT, lane index 0; valid_out=0,
//   data_out=0, frame_err=0, in_sync=0. Assembly register is not cleared.
//   Reset mid-frame discards the partial frame with no frame_err.
// - Inputs are ignored in any cycle with sample_valid==0: no state change.
// - HUNT: drop samples until sample_valid && sample_first. That sample goes
//   to lane 0; index = 1; state -> COLLECT.
// - COLLECT, index==k (k>0), valid sample:
//   - sample_first==0: write lane k, index++.
//   - sample_first==1 (early restart): frame_err=1 next cycle. Partial frame
//     discarded. Sample goes to lane 0, index = 1; stay in COLLECT.
// - COLLECT, index==0 (frame boundary), valid sample:
//   - sample_first==1: write lane 0, index = 1.
//   - sample_first==0: frame_err=1 next cycle. Sample dropped; state -> HUNT.
// - Frame completion: a valid sample written to lane NUM_INPUTS-1 completes
//   the frame. Next cycle: valid_out=1 for exactly one cycle and data_out =
//   the full vector, including that final sample. Index wraps to 0.
// - Latency: last sample in -> valid_out is 1 clk.
// - data_out holds its value until the next completion. No frame is lost
//   with back-to-back frames (sample_valid held high).
// - NUM_INPUTS==1: every sample with sample_first==1 completes a frame.
//   Index stays 0. A sample with sample_first==0 in COLLECT -> frame_err, HUNT.
// - frame_err and valid_out never assert in the same cycle.
// - in_sync is registered and reflects the current state.
// - Index counter width: $clog2(NUM_INPUTS), minimum 1 bit.
//
// STRUCTURE
// - Shared package dsbpm_pkg: typedef enum logic {HUNT, COLLECT} packer_state_t.
// - No sub-module. One FSM, one lane-index counter, a 2-D assembly register
//   [NUM_INPUTS-1:0][DATA_WIDTH-1:0], and an output shadow register flattened
//   onto data_out.
//
// TESTING (NUM_INPUTS=10, DATA_WIDTH=16 unless stated)
// 1. Reset, then 10 valid samples 0x0001..0x000A, first on sample 1 ->
//    valid_out 1 clk after sample 10; lane0=0x0001, lane9=0x000A; in_sync=1.
// 2. 3 frames back-to-back, sample_valid continuously high ->
//    3 valid_out strobes exactly 10 clks apart; every lane correct.
// 3. sample_first asserted on the 5th sample of a frame ->
//    frame_err pulse; no valid_out for the partial frame;
//    the frame restarted there completes normally.
// 4. 11th sample of a stream with sample_first=0 ->
//    frame_err; in_sync=0; samples dropped until the next first.
// 5. rst=0 for 1 clk after 6 samples ->
//    all outputs 0, HUNT; the next full frame is packed correctly.
// 6. NUM_INPUTS=1: samples 0x8000 and 0x7FFF, both first ->
//    two valid_out strobes with data_out=0x8000, then 0x7FFF.

Source files
------------

// File: rtl/dsbpm_pkg.sv
// Shared types for the DSBPM datapath blocks.
// Holds the packer FSM encoding and the lane-index width helper.
package dsbpm_pkg;

  typedef enum logic {HUNT, COLLECT} packer_state_t;

  // Lane-index width: enough bits to address every lane, never fewer than one.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sample_packer.sv
// Serial-to-parallel framer: gathers NUM_INPUTS framed samples into one flat
// vector and strobes valid_out for a cycle when the frame is complete.
module sample_packer
  import dsbpm_pkg::*;
#(
  parameter int NUM_INPUTS = 10,
  parameter int DATA_WIDTH = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             sample_valid,
  input  logic                             sample_first,
  input  logic [DATA_WIDTH-1:0]            sample_data,
  output logic                             valid_out,
  output logic [NUM_INPUTS*DATA_WIDTH-1:0] data_out,
  output logic                             frame_err,
  output logic                             in_sync
);

  localparam int                IDX_W    = idx_width(NUM_INPUTS);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_INPUTS - 1);

  typedef logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0] frame_t;

  packer_state_t    state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] wr_lane;
  logic             wr_en;
  logic             done_d, err_d;
  frame_t           asm_q, asm_d;
  frame_t           out_q;
  logic             valid_q, err_q, sync_q;

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    asm_d   = asm_q;
    wr_en   = 1'b0;
    wr_lane = '0;
    done_d  = 1'b0;
    err_d   = 1'b0;

    if (sample_valid) begin
      unique case (state_q)
        HUNT: begin
          if (sample_first) begin
            wr_en   = 1'b1;
            state_d = COLLECT;
          end
        end
        COLLECT: begin
          if (idx_q == '0) begin
            // At a frame boundary only a new frame start is legal.
            if (sample_first) begin
              wr_en = 1'b1;
            end else begin
              err_d   = 1'b1;
              state_d = HUNT;
            end
          end else begin
            wr_en = 1'b1;
            if (sample_first) begin
              err_d = 1'b1;   // early restart: the sample opens a fresh frame
            end else begin
              wr_lane = idx_q;
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end

    if (wr_en) begin
      for (int i = 0; i < NUM_INPUTS; i++) begin
        if (wr_lane == IDX_W'(i)) asm_d[i] = sample_data;
      end
      if (wr_lane == LAST_IDX) begin
        done_d = 1'b1;
        idx_d  = '0;
      end else begin
        idx_d  = wr_lane + IDX_W'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= HUNT;
      idx_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      sync_q  <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      valid_q <= done_d;
      err_q   <= err_d;
      sync_q  <= (state_d == COLLECT);
      if (done_d) out_q <= asm_d;
    end
  end

  // NOTE: the assembly register is deliberately not reset; stale lanes are never
  // published because a frame is only copied out once every lane has been rewritten.
  always_ff @(posedge clk) begin
    asm_q <= asm_d;
  end

  assign valid_out = valid_q;
  assign frame_err = err_q;
  assign in_sync   = sync_q;
  assign data_out  = out_q;

endmodule

// File: tb/tb_sample_packer.sv
// Directed bench for sample_packer: a 10-lane instance checked through a frame
// scoreboard and per-cycle strobe expectations, plus a single-lane instance.
module tb_sample_packer;

  localparam int N = 10;
  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           sample_valid = 1'b0, sample_first = 1'b0;
  logic [W-1:0]   sample_data = '0;
  logic           valid_out, frame_err, in_sync;
  logic [N*W-1:0] data_out;

  logic           s1_valid = 1'b0, s1_first = 1'b0;
  logic [W-1:0]   s1_data = '0;
  logic           s1_valid_out, s1_frame_err, s1_in_sync;
  logic [W-1:0]   s1_data_out;

  int checks = 0;
  int failures = 0;

  logic [N*W-1:0] exp_q[$];
  logic [N-1:0][W-1:0] asm_exp = '0;
  logic pend_valid = 1'b0, pend_err = 1'b0;
  int   cyc = 0, last_strobe = -1;
  int   gaps[$];

  always #5 clk = ~clk;

  sample_packer #(.NUM_INPUTS(N), .DATA_WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .sample_valid(sample_valid), .sample_first(sample_first), .sample_data(sample_data),
    .valid_out(valid_out), .data_out(data_out), .frame_err(frame_err), .in_sync(in_sync)
  );

  sample_packer #(.NUM_INPUTS(1), .DATA_WIDTH(W)) dut1 (
    .clk(clk), .rst(rst),
    .sample_valid(s1_valid), .sample_first(s1_first), .sample_data(s1_data),
    .valid_out(s1_valid_out), .data_out(s1_data_out), .frame_err(s1_frame_err),
    .in_sync(s1_in_sync)
  );

  task automatic check(input string tag, input logic [N*W-1:0] obs, input logic [N*W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: verify the outputs produced by the previous cycle's inputs,
  // then drive this cycle's sample and record what it should produce.
  task automatic step(input logic v, input logic f, input logic [W-1:0] d,
                      input int lane, input logic err_exp, input logic done_exp);
    logic [N*W-1:0] want;
    check("valid_out", valid_out, pend_valid);
    check("frame_err", frame_err, pend_err);
    if (valid_out) begin
      want = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      check("frame_data", data_out, want);
      if (last_strobe >= 0) gaps.push_back(cyc - last_strobe);
      last_strobe = cyc;
    end
    sample_valid = v;
    sample_first = f;
    sample_data  = d;
    if (lane >= 0) asm_exp[lane] = d;
    if (done_exp) exp_q.push_back(asm_exp);
    pend_valid = done_exp;
    pend_err   = err_exp;
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, '0, -1, 1'b0, 1'b0);
  endtask

  task automatic rst_step();
    rst = 1'b0;
    sample_valid = 1'b0;
    sample_first = 1'b0;
    pend_valid = 1'b0;
    pend_err = 1'b0;
    cyc++;
    @(negedge clk);
    check("rst_valid_out", valid_out, 1'b0);
    check("rst_data_out", data_out, '0);
    check("rst_frame_err", frame_err, 1'b0);
    check("rst_in_sync", in_sync, 1'b0);
    rst = 1'b1;
  endtask

  // Feed a full clean frame whose lane i carries base+i.
  task automatic full_frame(input logic [W-1:0] base);
    for (int i = 0; i < N; i++)
      step(1'b1, i == 0, base + W'(i), i, 1'b0, i == N - 1);
  endtask

  initial begin
    @(negedge clk);
    rst_step();
    rst_step();

    // 1: first frame 0x0001..0x000A
    full_frame(16'h0001);
    idle();
    check("t1_lane0", data_out[W-1:0], 16'h0001);
    check("t1_lane9", data_out[9*W +: W], 16'h000A);
    check("t1_in_sync", in_sync, 1'b1);

    // 2: three frames back to back, strobes 10 cycles apart
    gaps.delete();
    last_strobe = -1;
    full_frame(16'h0100);
    full_frame(16'h0200);
    full_frame(16'h0300);
    idle();
    check("t2_gap_count", gaps.size(), 2);
    check("t2_gap0", gaps[0], 10);
    check("t2_gap1", gaps[1], 10);

    // 3: restart on the 5th sample, restarted frame completes
    for (int i = 0; i < 4; i++) step(1'b1, i == 0, 16'hA000 + W'(i), i, 1'b0, 1'b0);
    step(1'b1, 1'b1, 16'hB000, 0, 1'b1, 1'b0);
    for (int i = 1; i < N; i++) step(1'b1, 1'b0, 16'hB000 + W'(i), i, 1'b0, i == N - 1);

    // 4: 11th sample not first -> error, hunt, drop until next first
    step(1'b1, 1'b0, 16'hDEAD, -1, 1'b1, 1'b0);
    idle();
    check("t4_in_sync", in_sync, 1'b0);
    step(1'b1, 1'b0, 16'h1111, -1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 16'h2222, -1, 1'b0, 1'b0);
    check("t4_still_hunting", in_sync, 1'b0);
    full_frame(16'hC000);
    idle();

    // 5: reset after 6 samples, then a clean frame
    for (int i = 0; i < 6; i++) step(1'b1, i == 0, 16'hE000 + W'(i), i, 1'b0, 1'b0);
    idle();
    rst_step();
    full_frame(16'hF000);
    idle();
    check("t5_lane0", data_out[W-1:0], 16'hF000);
    check("t5_lane9", data_out[9*W +: W], 16'hF009);
    check("scoreboard_empty", exp_q.size(), 0);

    // 6: single-lane packer
    s1_valid = 1'b1; s1_first = 1'b1; s1_data = 16'h8000;
    @(negedge clk);
    check("t6_valid_a", s1_valid_out, 1'b1);
    check("t6_data_a", s1_data_out, 16'h8000);
    s1_data = 16'h7FFF;
    @(negedge clk);
    check("t6_valid_b", s1_valid_out, 1'b1);
    check("t6_data_b", s1_data_out, 16'h7FFF);
    check("t6_sync", s1_in_sync, 1'b1);
    s1_first = 1'b0; s1_data = 16'h1234;
    @(negedge clk);
    check("t6_err", s1_frame_err, 1'b1);
    check("t6_no_valid", s1_valid_out, 1'b0);
    check("t6_hunt", s1_in_sync, 1'b0);
    check("t6_data_hold", s1_data_out, 16'h7FFF);
    s1_valid = 1'b0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
